// File: rtl/skip_adder_pkg.sv
// skip_adder_pkg: configuration helpers shared by the pipelined carry-skip adder
package skip_adder_pkg;

   // A configuration is usable only if every stage gets a whole number of skip blocks
   function automatic bit legal_cfg(input int width, input int block, input int stages);
      return width >= 1 && block >= 1 && stages >= 1 && (width % (stages * block)) == 0;
   endfunction

   // Bits resolved per pipeline stage
   function automatic int slice_w(input int width, input int stages);
      return stages >= 1 ? width / stages : width;
   endfunction

   // Skip blocks per pipeline stage
   function automatic int nblk_w(input int width, input int block, input int stages);
      return block >= 1 ? slice_w(width, stages) / block : 1;
   endfunction

endpackage

// File: rtl/skip_block.sv
// skip_block: BLOCK-bit ripple adder exposing group propagate for an external skip mux
module skip_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             cout,
   output logic             prop_all,
   output logic             c_msb_in
);
   logic [BLOCK:0]   c;
   logic [BLOCK-1:0] p;

   // ripple carry through the block; cout is the unskipped carry out of the MSB
   always_comb begin
      p    = a ^ b;
      c[0] = cin;
      for (int i = 0; i < BLOCK; i++) c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
      s        = p ^ c[BLOCK-1:0];
      cout     = c[BLOCK];
      prop_all = &p;
      c_msb_in = c[BLOCK-1];
   end

endmodule

// File: rtl/skip_adder_pipe.sv
// skip_adder_pipe: parametrised skewed-pipeline carry-skip adder/subtractor with valid/ready
module skip_adder_pipe
   import skip_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);
   localparam int SLICE = slice_w(WIDTH, STAGES);
   localparam int NBLK  = nblk_w(WIDTH, BLOCK, STAGES);

   if (!legal_cfg(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
      $error("skip_adder_pipe: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
   end

   // index k is the token entering stage k; index STAGES is the pipe output
   logic [WIDTH-1:0] a_st [STAGES];
   logic [WIDTH-1:0] b_st [STAGES];
   logic [WIDTH-1:0] s_st [STAGES+1];
   logic             c_st [STAGES+1];
   logic [STAGES:0]  vv;
   logic [STAGES:0]  rdy;

   // subtraction is a + ~b + ~borrow, so operand prep happens once at the input
   assign a_st[0] = a;
   assign b_st[0] = b ^ {WIDTH{sub}};
   assign c_st[0] = ci ^ sub;
   assign s_st[0] = '0;
   assign vv[0]   = in_valid;

   // ready ripples back from the consumer: a stage loads when empty or when its successor drains
   always_comb begin
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) rdy[k] = ~vv[k+1] | rdy[k+1];
   end

   assign in_ready  = rdy[0];
   assign out_valid = vv[STAGES];
   assign s         = s_st[STAGES];
   assign co        = c_st[STAGES];
   assign ovf       = g_st[STAGES-1].g_last.ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic [SLICE-1:0]       sl;
      logic [SLICE+WIDTH-1:0] cat;
      logic [WIDTH-1:0]       s_q;
      logic                   c_q;
      logic                   v_q;

      for (genvar j = 0; j < NBLK; j++) begin : g_blk
         logic cin, rc, pa, cm, cout;
         if (j == 0) begin : g_c0
            assign cin = c_st[k];
         end else begin : g_cn
            assign cin = g_blk[j-1].cout;
         end
         skip_block #(.BLOCK(BLOCK)) u_blk (
            .a        (a_st[k][j*BLOCK +: BLOCK]),
            .b        (b_st[k][j*BLOCK +: BLOCK]),
            .cin      (cin),
            .s        (sl[j*BLOCK +: BLOCK]),
            .cout     (rc),
            .prop_all (pa),
            .c_msb_in (cm)
         );
         // a fully propagating block forwards its carry-in instead of waiting on the ripple
         assign cout = pa ? cin : rc;
      end

      // new slice enters at the top; after STAGES shifts the slices sit in bit order
      assign cat       = {sl, s_st[k]};
      assign vv[k+1]   = v_q;
      assign s_st[k+1] = s_q;
      assign c_st[k+1] = c_q;

      // token advances when this stage can load; data captured only for valid tokens
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            v_q <= 1'b0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (rdy[k]) begin
            v_q <= vv[k];
            if (vv[k]) begin
               s_q <= cat[SLICE+WIDTH-1 -: WIDTH];
               c_q <= g_blk[NBLK-1].cout;
            end
         end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] a_q, b_q;
         assign a_st[k+1] = a_q;
         assign b_st[k+1] = b_q;
         // drop the consumed slice so the next stage always works on the low operand bits
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (rdy[k] && vv[k]) begin
               a_q <= a_st[k] >> SLICE;
               b_q <= b_st[k] >> SLICE;
            end
      end else begin : g_last
         logic ovf_q;
         // signed overflow: carry into the MSB differs from carry out of it
         always_ff @(posedge clk or posedge rst)
            if (rst) ovf_q <= 1'b0;
            else if (rdy[k] && vv[k]) ovf_q <= g_blk[NBLK-1].cm ^ g_blk[NBLK-1].cout;
      end
   end

endmodule

// File: tb/tb_skip_adder_pipe.sv
// tb_skip_adder_pipe: scoreboard bench for the pipelined carry-skip adder at WIDTH=8/BLOCK=4/STAGES=2
module tb_skip_adder_pipe;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         ci = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, co, ovf;
   logic [W-1:0] s;

   int           checks = 0;
   int           failures = 0;
   logic [W+1:0] q[$];

   always #5 clk = ~clk;

   skip_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .ovf       (ovf)
   );

   // reference: {co, ovf, s} from plain integer arithmetic and sign rules
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic m);
      logic [W-1:0] ye;
      logic         ce;
      logic [W:0]   r;
      ye = m ? ~y : y;
      ce = m ? ~c : c;
      r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
      return {r[W], (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]), r[W-1:0]};
   endfunction

   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, input logic isub, input logic ior);
      @(negedge clk);
      in_valid  = iv;
      a         = iv ? ia : 'x;
      b         = iv ? ib : 'x;
      ci        = iv ? ici : 1'bx;
      sub       = iv ? isub : 1'bx;
      out_ready = ior;
      #1;
   endtask

   task automatic issue_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                            input logic isub, output logic [W+1:0] got, output int lat);
      int n;
      n = 0;
      step(1'b1, ia, ib, ici, isub, 1'b1);
      while (!in_ready && n < 20) begin
         step(1'b1, ia, ib, ici, isub, 1'b1);
         n++;
      end
      lat = 0;
      got = '0;
      repeat (10) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         lat++;
         if (out_valid) begin
            got = {co, ovf, s};
            break;
         end
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({out_valid, co, ovf, s} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got valid/co/ovf/s=%b/%b/%b/%h expected 0/0/0/00", out_valid, co, ovf, s);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_add;
      logic [W+1:0] got;
      int           lat;
      logic [W-1:0] ta [2] = '{8'd5, 8'd100};
      logic [W-1:0] tv [2] = '{8'd10, 8'd200};
      logic         tc [2] = '{1'b1, 1'b0};
      logic [W+1:0] te [2] = '{{1'b0, 1'b0, 8'd16}, {1'b1, 1'b0, 8'd44}};
      for (int i = 0; i < 2; i++) begin
         issue_one(ta[i], tv[i], tc[i], 1'b0, got, lat);
         checks++;
         if (got !== te[i]) begin
            failures++;
            $display("FAIL add[%0d]: got co,ovf,s=%h expected %h", i, got, te[i]);
         end
         checks++;
         if (lat != 2) begin
            failures++;
            $display("FAIL add_latency[%0d]: got %0d expected 2", i, lat);
         end
      end
   endtask

   task automatic test_overflow_skip;
      logic [W+1:0] got;
      int           lat;
      logic [W-1:0] ta [2] = '{8'd127, 8'd255};
      logic [W-1:0] tv [2] = '{8'd127, 8'd0};
      logic [W+1:0] te [2] = '{{1'b0, 1'b1, 8'd255}, {1'b1, 1'b0, 8'd0}};
      for (int i = 0; i < 2; i++) begin
         issue_one(ta[i], tv[i], 1'b1, 1'b0, got, lat);
         checks++;
         if (got !== te[i] || lat != 2) begin
            failures++;
            $display("FAIL ovf_skip[%0d]: got co,ovf,s=%h lat=%0d expected %h lat=2", i, got, lat, te[i]);
         end
      end
   endtask

   task automatic test_sub;
      logic [W+1:0] got;
      int           lat;
      logic [W-1:0] ta [3] = '{8'd10, 8'd5, 8'd128};
      logic [W-1:0] tv [3] = '{8'd5, 8'd10, 8'd1};
      logic [W+1:0] te [3] = '{{1'b1, 1'b0, 8'd5}, {1'b0, 1'b0, 8'd251}, {1'b1, 1'b1, 8'd127}};
      for (int i = 0; i < 3; i++) begin
         issue_one(ta[i], tv[i], 1'b0, 1'b1, got, lat);
         checks++;
         if (got !== te[i] || lat != 2) begin
            failures++;
            $display("FAIL sub[%0d]: got co,ovf,s=%h lat=%0d expected %h lat=2", i, got, lat, te[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] x, y;
      logic         c, m;
      int           got_n;
      got_n = 0;
      q.delete();
      for (int i = 0; i < 12; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom);
         m = 1'($urandom);
         step(i < 8, x, y, c, m, 1'b1);
         if (i < 8) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
         end
         checks++;
         if (out_valid !== (i >= 2 && i < 10)) begin
            failures++;
            $display("FAIL b2b_out_valid[%0d]: got %b expected %b", i, out_valid, (i >= 2 && i < 10));
         end
         if (in_valid && in_ready) q.push_back(model(x, y, c, m));
         if (out_valid && out_ready) begin
            got_n++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: got %h expected no result", {co, ovf, s});
            end else if ({co, ovf, s} !== q[0]) begin
               failures++;
               $display("FAIL b2b_data: got %h expected %h", {co, ovf, s}, q.pop_front());
            end else void'(q.pop_front());
         end
      end
      checks++;
      if (got_n != 8 || q.size() != 0) begin
         failures++;
         $display("FAIL b2b_count: got %0d results expected 8", got_n);
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] x, y;
      logic         c, m;
      logic [W+1:0] held;
      int           sent, got_n;
      sent  = 0;
      got_n = 0;
      held  = '0;
      q.delete();
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
      m = 1'($urandom);
      for (int cyc = 0; cyc < 40; cyc++) begin
         step(sent < 5, x, y, c, m, cyc >= 6);
         if (cyc == 2) held = {co, ovf, s};
         if (cyc == 3) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL bp_full: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
            end
         end
         if (cyc == 5) begin
            checks++;
            if ({co, ovf, s} !== held) begin
               failures++;
               $display("FAIL bp_hold: got %h expected %h", {co, ovf, s}, held);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(x, y, c, m));
            sent++;
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            m = 1'($urandom);
         end
         if (out_valid && out_ready) begin
            got_n++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra: got %h expected no result", {co, ovf, s});
            end else if ({co, ovf, s} !== q[0]) begin
               failures++;
               $display("FAIL bp_data: got %h expected %h", {co, ovf, s}, q.pop_front());
            end else void'(q.pop_front());
         end
      end
      checks++;
      if (got_n != 5 || sent != 5) begin
         failures++;
         $display("FAIL bp_count: got %0d results of %0d sent expected 5", got_n, sent);
      end
   endtask

   task automatic test_reset_mid;
      logic pre;
      int   stale;
      stale = 0;
      q.delete();
      step(1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      pre = out_valid;
      rst = 1'b1;
      #1;
      checks++;
      if (pre !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: got out_valid=%b expected 1", pre);
      end
      checks++;
      if ({out_valid, co, ovf, s} !== '0) begin
         failures++;
         $display("FAIL rst_mid_async: got valid/co/ovf/s=%b/%b/%b/%h expected 0/0/0/00", out_valid, co, ovf, s);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         failures++;
         $display("FAIL rst_mid_stale: got %0d stale results expected 0", stale);
      end
   endtask

   task automatic test_random;
      localparam int N = 10000;
      logic [W-1:0] x, y;
      logic         c, m, iv, hold, ohold;
      logic [W+1:0] last_out;
      int           sent, cyc;
      sent  = 0;
      cyc   = 0;
      hold  = 1'b0;
      ohold = 1'b0;
      last_out = '0;
      x = '0;
      y = '0;
      c = 1'b0;
      m = 1'b0;
      q.delete();
      while ((sent < N || q.size() != 0) && cyc < 60000) begin
         iv = hold || (sent < N && $urandom_range(3) != 0);
         if (!hold) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            m = 1'($urandom);
         end
         step(iv, x, y, c, m, $urandom_range(3) != 0);
         if (ohold) begin
            checks++;
            if (!out_valid || {co, ovf, s} !== last_out) begin
               failures++;
               $display("FAIL rnd_hold: got valid=%b %h expected 1 %h", out_valid, {co, ovf, s}, last_out);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(x, y, c, m));
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL rnd_extra: got %h expected no result", {co, ovf, s});
            end else if ({co, ovf, s} !== q[0]) begin
               failures++;
               $display("FAIL rnd_data: got %h expected %h", {co, ovf, s}, q.pop_front());
            end else void'(q.pop_front());
         end
         hold     = in_valid && !in_ready;
         ohold    = out_valid && !out_ready;
         last_out = {co, ovf, s};
         cyc++;
      end
      checks++;
      if (sent != N || q.size() != 0) begin
         failures++;
         $display("FAIL rnd_timeout: got %0d sent %0d pending expected %0d sent 0 pending", sent, q.size(), N);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      test_add;
      test_overflow_skip;
      test_sub;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
